// File: rtl/riscv_icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package riscv_icache_pkg;

    typedef enum logic [1:0] {
        LOOKUP,
        REFILL,
        FLUSH
    } icache_state_e;

    // Wide enough for the largest supported associativity (8 ways).
    typedef logic [2:0] way_idx_t;

    function automatic int log2_of(input int value);
        return (value > 1) ? $clog2(value) : 0;
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_bits(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/riscv_icache_plru.sv
// Tree-PLRU helper: victim from a set's PLRU bits and the bits after an access.
module riscv_icache_plru
    import riscv_icache_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    localparam int PW = plru_bits(NUM_WAYS)
) (
    input  logic [PW-1:0] plru,
    input  way_idx_t      access_way,
    output way_idx_t      victim,
    output logic [PW-1:0] plru_next
);

    localparam int LEVELS = log2_of(NUM_WAYS);

    logic unused_plru_in;
    assign unused_plru_in = ^{plru, access_way};

    // A node bit of 1 means the older half lies in the right subtree.
    always_comb begin
        int  node;
        logic dir;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        victim = '0;
        node   = 0;
        dir    = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            dir    = plru[node];
            victim = {victim[1:0], dir};
            node   = 2 * node + 1 + int'(dir);
        end
    end

    always_comb begin
        int  node;
        logic dir;
        plru_next = plru;
        node      = 0;
        dir       = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            dir             = access_way[LEVELS-1-l];
            plru_next[node] = ~dir;
            node            = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/riscv_core_icache_assoc.sv
// N-way set-associative instruction cache with tree-PLRU and sequential flush.
// Optional hit/miss counters are built when RISCV_ICACHE_PERF_CNT_EN is defined.
module riscv_core_icache_assoc
    import riscv_icache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int NUM_SETS        = 128,
    parameter int NUM_WAYS        = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
    input  logic                       i_flush,
    output logic                       o_stall,
    output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
    output logic [ADDR_WIDTH-1:0]      o_addr_from_control_to_axi,
    output logic                       o_mem_req,
    input  logic                       i_mem_done,
    input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi
`ifdef RISCV_ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                o_hit_cnt,
    output logic [31:0]                o_miss_cnt
`endif
);

    localparam int BYTE_OFF = log2_of(CORE_DATA_WIDTH / 8);
    localparam int BLK_OFF  = log2_of(AXI_DATA_WIDTH / CORE_DATA_WIDTH);
    localparam int IDX      = log2_of(NUM_SETS);
    localparam int LINE_OFF = BLK_OFF + BYTE_OFF;
    localparam int TAG      = ADDR_WIDTH - IDX - LINE_OFF;
    localparam int WAY_W    = way_bits(NUM_WAYS);
    localparam int PW       = plru_bits(NUM_WAYS);
    localparam logic [IDX-1:0] LAST_SET = IDX'(NUM_SETS - 1);

    icache_state_e        state_q;
    logic                 flush_pending_q;
    logic [IDX-1:0]       flush_cnt_q;
    logic [WAY_W-1:0]     victim_q;

    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [PW-1:0]        plru_q  [NUM_SETS];
    logic [TAG-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [AXI_DATA_WIDTH-1:0] data_q [NUM_SETS][NUM_WAYS];

    logic [IDX-1:0]       idx, refill_idx, plru_sel_idx;
    logic [TAG-1:0]       tag;
    logic [BLK_OFF-1:0]   word_sel;
    logic                 hit, stall_raw;
    logic [WAY_W-1:0]     hit_way, victim_way;
    way_idx_t             plru_victim, plru_access;
    logic [PW-1:0]        plru_next;

    assign idx        = i_addr_from_core[LINE_OFF +: IDX];
    assign tag        = i_addr_from_core[ADDR_WIDTH-1 -: TAG];
    assign word_sel   = i_addr_from_core[BYTE_OFF +: BLK_OFF];
    assign refill_idx = o_addr_from_control_to_axi[LINE_OFF +: IDX];

    logic unused_bits;
    assign unused_bits = ^{i_addr_from_core[BYTE_OFF-1:0], plru_victim};

    // Descending scans so the lowest matching way wins.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = plru_victim[WAY_W-1:0];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim_way = WAY_W'(w);
        end
    end

    assign o_data_to_core = data_q[idx][hit_way][word_sel*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];

    always_comb begin
        stall_raw = 1'b1;
        if (state_q == LOOKUP) stall_raw = i_flush || !hit;
    end
    assign o_stall = i_rst_n & stall_raw;

    // The single PLRU helper serves the fetch set in LOOKUP and the refill set in REFILL.
    assign plru_sel_idx = (state_q == REFILL) ? refill_idx : idx;
    assign plru_access  = (state_q == REFILL) ? way_idx_t'(victim_q) : way_idx_t'(hit_way);

    riscv_icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .plru       (plru_q[plru_sel_idx]),
        .access_way (plru_access),
        .victim     (plru_victim),
        .plru_next  (plru_next)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q                    <= LOOKUP;
            flush_pending_q            <= 1'b0;
            flush_cnt_q                <= '0;
            victim_q                   <= '0;
            o_mem_req                  <= 1'b0;
            o_addr_from_control_to_axi <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state_q)
                LOOKUP: begin
                    if (i_flush) begin
                        flush_cnt_q <= '0;
                        state_q     <= FLUSH;
                    end else if (hit) begin
                        plru_q[idx] <= plru_next;
                    end else begin
                        o_addr_from_control_to_axi <= {i_addr_from_core[ADDR_WIDTH-1:LINE_OFF],
                                                       {LINE_OFF{1'b0}}};
                        victim_q  <= victim_way;
                        o_mem_req <= 1'b1;
                        state_q   <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_flush) flush_pending_q <= 1'b1;
                    if (i_mem_done) begin
                        valid_q[refill_idx][victim_q] <= 1'b1;
                        plru_q[refill_idx]            <= plru_next;
                        o_mem_req                     <= 1'b0;
                        flush_pending_q               <= 1'b0;
                        flush_cnt_q                   <= '0;
                        state_q <= (flush_pending_q || i_flush) ? FLUSH : LOOKUP;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt_q] <= '0;
                    plru_q[flush_cnt_q]  <= '0;
                    if (flush_cnt_q == LAST_SET) begin
                        flush_cnt_q <= '0;
                        state_q     <= LOOKUP;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide what is resident.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && state_q == REFILL && i_mem_done) begin
            data_q[refill_idx][victim_q] <= i_block_from_axi;
            tag_q[refill_idx][victim_q]  <= o_addr_from_control_to_axi[ADDR_WIDTH-1 -: TAG];
        end
    end

`ifdef RISCV_ICACHE_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else begin
            if (state_q == LOOKUP && !o_stall && o_hit_cnt != '1)
                o_hit_cnt <= o_hit_cnt + 32'd1;
            if (state_q == LOOKUP && !i_flush && !hit && o_miss_cnt != '1)
                o_miss_cnt <= o_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_icache_assoc.sv
// Directed self-checking bench for riscv_core_icache_assoc at default parameters.
// Counter checks are compiled in when RISCV_ICACHE_PERF_CNT_EN is defined.
module tb_riscv_core_icache_assoc;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [63:0]  i_addr_from_core = '0;
    logic         i_flush = 1'b0;
    logic         o_stall;
    logic [31:0]  o_data_to_core;
    logic [63:0]  o_addr_from_control_to_axi;
    logic         o_mem_req;
    logic         i_mem_done = 1'b0;
    logic [255:0] i_block_from_axi = '0;
`ifdef RISCV_ICACHE_PERF_CNT_EN
    logic [31:0]  o_hit_cnt;
    logic [31:0]  o_miss_cnt;
`endif

    int passed = 0;
    int total  = 0;

    riscv_core_icache_assoc dut (
        .i_clk                      (i_clk),
        .i_rst_n                    (i_rst_n),
        .i_addr_from_core           (i_addr_from_core),
        .i_flush                    (i_flush),
        .o_stall                    (o_stall),
        .o_data_to_core             (o_data_to_core),
        .o_addr_from_control_to_axi (o_addr_from_control_to_axi),
        .o_mem_req                  (o_mem_req),
        .i_mem_done                 (i_mem_done),
        .i_block_from_axi           (i_block_from_axi)
`ifdef RISCV_ICACHE_PERF_CNT_EN
        ,
        .o_hit_cnt                  (o_hit_cnt),
        .o_miss_cnt                 (o_miss_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Word k of the line is base + k.
    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_flush    = 1'b0;
        i_mem_done = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Presents a missing address, waits for the request, answers after lat cycles.
    task automatic refill(input logic [63:0] addr, input logic [255:0] line, input int lat,
                          input string name);
        int n;
        i_addr_from_core = addr;
        #1;
        total++;
        if (o_stall !== 1'b1) $display("FAIL %s_miss_stall: got %b want 1", name, o_stall);
        else passed++;
        n = 0;
        while (o_mem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        total++;
        if (o_mem_req !== 1'b1) $display("FAIL %s_req: got %b want 1 within 8 cycles", name, o_mem_req);
        else passed++;
        total++;
        if (o_addr_from_control_to_axi !== (addr & ~64'h1F))
            $display("FAIL %s_axi_addr: got %h want %h", name, o_addr_from_control_to_axi, addr & ~64'h1F);
        else passed++;
        repeat (lat) tick();
        i_mem_done       = 1'b1;
        i_block_from_axi = line;
        tick();
        i_mem_done       = 1'b0;
        i_block_from_axi = '0;
    endtask

    // Counts cycles from the current point until o_mem_req rises, tracking o_stall.
    task automatic wait_req(output int n, output bit stall_ok);
        n = 0;
        stall_ok = 1'b1;
        while (o_mem_req !== 1'b1 && n < 400) begin
            if (o_stall !== 1'b1) stall_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        i_addr_from_core = 64'h1000;
        do_reset();
        i_rst_n = 1'b0;
        tick();
        total++;
        if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall);
        else passed++;
        total++;
        if (o_mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", o_mem_req);
        else passed++;
        total++;
        if (o_addr_from_control_to_axi !== 64'h0)
            $display("FAIL reset_axi_addr: got %h want 0", o_addr_from_control_to_axi);
        else passed++;
`ifdef RISCV_ICACHE_PERF_CNT_EN
        total++;
        if (o_hit_cnt !== 32'd0 || o_miss_cnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_hit_cnt, o_miss_cnt);
        else passed++;
`endif
        i_rst_n = 1'b1;
        #1;
        total++;
        if (o_stall !== 1'b1) $display("FAIL reset_cold_stall: got %b want 1", o_stall);
        else passed++;
    endtask

    task automatic test_cold_miss();
        logic [255:0] line;
        line = mk_line(32'h1000_0000);
        line[32 +: 32] = 32'hDEADBEEF;
        refill(64'h1004, line, 5, "cold");
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hDEADBEEF)
            $display("FAIL cold_hit: got stall=%b data=%h want stall=0 data=deadbeef", o_stall, o_data_to_core);
        else passed++;
        total++;
        if (o_mem_req !== 1'b0) $display("FAIL cold_req_drop: got %b want 0", o_mem_req);
        else passed++;
        i_addr_from_core = 64'h101C;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'h1000_0007)
            $display("FAIL cold_word7: got stall=%b data=%h want stall=0 data=10000007", o_stall, o_data_to_core);
        else passed++;
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        refill(64'h0000, mk_line(32'hA000_0000), 2, "fill_a");
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hA000_0000)
            $display("FAIL fill_a_hit: got stall=%b data=%h want 0/a0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        refill(64'h1000, mk_line(32'hB000_0000), 2, "fill_b");
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB000_0000)
            $display("FAIL fill_b_hit: got stall=%b data=%h want 0/b0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        i_addr_from_core = 64'h0008;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hA000_0002)
            $display("FAIL rehit_a: got stall=%b data=%h want 0/a0000002", o_stall, o_data_to_core);
        else passed++;
        tick();
        total++;
        if (o_mem_req !== 1'b0) $display("FAIL rehit_a_req: got %b want 0", o_mem_req);
        else passed++;
        // 0x1000 touched last, so 0x0000 becomes the victim.
        i_addr_from_core = 64'h1000;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB000_0000)
            $display("FAIL rehit_b: got stall=%b data=%h want 0/b0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        refill(64'h2000, mk_line(32'hC000_0000), 2, "fill_c");
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hC000_0000)
            $display("FAIL fill_c_hit: got stall=%b data=%h want 0/c0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        i_addr_from_core = 64'h1000;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB000_0000)
            $display("FAIL keep_b: got stall=%b data=%h want 0/b0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        i_addr_from_core = 64'h0000;
        #1;
        total++;
        if (o_stall !== 1'b1) $display("FAIL evict_a: got stall=%b want 1", o_stall);
        else passed++;
        // 0x1000 is now MRU, so 0x0000 displaces 0x2000.
        refill(64'h0000, mk_line(32'hA100_0000), 1, "refill_a");
        tick();
        i_addr_from_core = 64'h1000;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB000_0000)
            $display("FAIL keep_b2: got stall=%b data=%h want 0/b0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
        i_addr_from_core = 64'h2000;
        #1;
        total++;
        if (o_stall !== 1'b1) $display("FAIL evict_c: got stall=%b want 1", o_stall);
        else passed++;
    endtask

    task automatic test_flush();
        int  n;
        bit  stall_ok;
        do_reset();
        refill(64'h1000, mk_line(32'hB000_0000), 1, "flush_fill");
        tick();
        i_flush = 1'b1;
        #1;
        total++;
        if (o_stall !== 1'b1) $display("FAIL flush_priority: got stall=%b want 1", o_stall);
        else passed++;
        tick();
        i_flush = 1'b0;
        // 128 flush cycles plus the re-lookup cycle before the miss is requested.
        wait_req(n, stall_ok);
        total++;
        if (n !== 129 || !stall_ok)
            $display("FAIL flush_len: got %0d cycles stall_ok=%0d want 129 cycles stall_ok=1", n, stall_ok);
        else passed++;
        total++;
        if (o_addr_from_control_to_axi !== 64'h1000)
            $display("FAIL flush_remiss: got %h want 1000", o_addr_from_control_to_axi);
        else passed++;
        i_mem_done       = 1'b1;
        i_block_from_axi = mk_line(32'hB200_0000);
        tick();
        i_mem_done = 1'b0;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB200_0000)
            $display("FAIL flush_refill_hit: got stall=%b data=%h want 0/b2000000", o_stall, o_data_to_core);
        else passed++;
        tick();
    endtask

    task automatic test_flush_in_refill();
        int  n;
        bit  stall_ok;
        do_reset();
        i_addr_from_core = 64'h1000;
        tick();
        total++;
        if (o_mem_req !== 1'b1) $display("FAIL fir_req: got %b want 1", o_mem_req);
        else passed++;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        i_mem_done       = 1'b1;
        i_block_from_axi = mk_line(32'hB000_0000);
        tick();
        i_mem_done = 1'b0;
        total++;
        if (o_stall !== 1'b1 || o_mem_req !== 1'b0)
            $display("FAIL fir_enter_flush: got stall=%b req=%b want 1/0", o_stall, o_mem_req);
        else passed++;
        wait_req(n, stall_ok);
        total++;
        if (n !== 129 || !stall_ok)
            $display("FAIL fir_len: got %0d cycles stall_ok=%0d want 129 cycles stall_ok=1", n, stall_ok);
        else passed++;
        i_mem_done       = 1'b1;
        i_block_from_axi = mk_line(32'hB300_0000);
        tick();
        i_mem_done = 1'b0;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hB300_0000)
            $display("FAIL fir_hit: got stall=%b data=%h want 0/b3000000", o_stall, o_data_to_core);
        else passed++;
        tick();
    endtask

    task automatic test_reset_in_refill();
        do_reset();
        i_addr_from_core = 64'h2000;
        tick();
        total++;
        if (o_mem_req !== 1'b1) $display("FAIL rir_req: got %b want 1", o_mem_req);
        else passed++;
        i_rst_n = 1'b0;
        tick();
        total++;
        if (o_mem_req !== 1'b0 || o_stall !== 1'b0)
            $display("FAIL rir_drop: got req=%b stall=%b want 0/0", o_mem_req, o_stall);
        else passed++;
        i_rst_n          = 1'b1;
        i_mem_done       = 1'b1;
        i_block_from_axi = mk_line(32'hEEEE_0000);
        tick();
        i_mem_done       = 1'b0;
        i_block_from_axi = '0;
        total++;
        if (o_stall !== 1'b1 || o_mem_req !== 1'b1)
            $display("FAIL rir_stray: got stall=%b req=%b want 1/1", o_stall, o_mem_req);
        else passed++;
        tick();
        i_mem_done       = 1'b1;
        i_block_from_axi = mk_line(32'hC000_0000);
        tick();
        i_mem_done = 1'b0;
        total++;
        if (o_stall !== 1'b0 || o_data_to_core !== 32'hC000_0000)
            $display("FAIL rir_hit: got stall=%b data=%h want 0/c0000000", o_stall, o_data_to_core);
        else passed++;
        tick();
    endtask

`ifdef RISCV_ICACHE_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        refill(64'h1000, mk_line(32'hB000_0000), 1, "perf_fill");
        repeat (3) tick();
        i_addr_from_core = 64'h3000;
        #1;
        total++;
        if (o_miss_cnt !== 32'd1 || o_hit_cnt !== 32'd3)
            $display("FAIL perf_cnt: got miss=%0d hit=%0d want 1/3", o_miss_cnt, o_hit_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush();
        test_flush_in_refill();
        test_reset_in_refill();
`ifdef RISCV_ICACHE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_core_icache_assoc.md
Name: riscv_core_icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache. Successor to the direct-mapped icache controller/memory pair.
- Sits between the core fetch stage and the AXI refill master.
- Keeps the same core/AXI handshake (combinational hit, o_stall, o_mem_req/i_mem_done block refill).
- Adds configurable ways and sets, tree-PLRU replacement, and a sequential flush.

Parameters:
- ADDR_WIDTH, 64, fetch/refill address width.
- CORE_DATA_WIDTH, 32, instruction word width.
- AXI_DATA_WIDTH, 256, cache line width; one refill beat = one line.
- NUM_SETS, 128, sets; power of 2, ≥2.
- NUM_WAYS, 2, associativity; power of 2, 1..8.
- Derived: BYTE_OFF=log2(CORE_DATA_WIDTH/8), BLK_OFF=log2(AXI_DATA_WIDTH/CORE_DATA_WIDTH), IDX=log2(NUM_SETS), TAG=ADDR_WIDTH-IDX-BLK_OFF-BYTE_OFF.

Ports:
- i_clk  in  1  clock, single domain.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_addr_from_core  in  ADDR_WIDTH  fetch address, word aligned.
- i_flush  in  1  invalidate-all request (fence.i); pulse.
- o_stall  out  1  fetch must hold; o_data_to_core invalid.
- o_data_to_core  out  CORE_DATA_WIDTH  fetched word.
- o_addr_from_control_to_axi  out  ADDR_WIDTH  line-aligned refill address.
- o_mem_req  out  1  refill request, level.
- i_mem_done  in  1  one-cycle pulse; i_block_from_axi valid.
- i_block_from_axi  in  AXI_DATA_WIDTH  refill line, word 0 at LSBs.

Behaviour:
- Reset (synchronous on i_clk when i_rst_n=0):
  - All valid bits and PLRU bits 0, state LOOKUP, flush_pending 0.
  - o_mem_req=0, o_addr_from_control_to_axi=0.
  - o_stall is combinational: deasserted under reset.
  - Tag and data arrays are not reset.
- States: LOOKUP, REFILL, FLUSH.
- LOOKUP:
  - Compare the tag of the set addressed by i_addr_from_core against all ways, combinationally.
  - Hit: o_stall=0; o_data_to_core = word BLK_OFF of the hit way, same cycle; PLRU of that set updated at the clock edge.
  - Miss: o_stall=1; latch the line-aligned address (low BLK_OFF+BYTE_OFF bits zeroed) and the victim way; next state REFILL.
- REFILL:
  - o_mem_req=1 and o_stall=1; address held stable until i_mem_done.
  - On i_mem_done: write line, tag, valid=1 into the victim way; mark the victim MRU; o_mem_req=0 next cycle; return to LOOKUP.
  - The core keeps the same address, so the re-lookup hits one cycle after i_mem_done.
  - Miss-to-data latency = AXI latency + 2 cycles.
- Victim selection: lowest-index invalid way; otherwise tree-PLRU victim. NUM_WAYS=1 always selects way 0.
- FLUSH:
  - o_stall=1; clears valid bits for one set per cycle, index counter 0..NUM_SETS-1.
  - After the last set, counter wraps to 0 and state returns to LOOKUP. Takes exactly NUM_SETS cycles.
  - PLRU bits are also cleared.
- i_flush in LOOKUP: takes priority over hit/miss that cycle; o_stall=1; enter FLUSH.
- i_flush in REFILL: sets flush_pending. Refill completes normally, then FLUSH is entered instead of LOOKUP.
- i_flush in FLUSH: ignored.
- i_mem_done outside REFILL: ignored.
- Reset mid-REFILL: o_mem_req drops in the reset cycle. Any later i_mem_done is ignored.
- An address change while stalled is a core protocol violation and is not handled.

Optional Feature:
- Macro RISCV_ICACHE_PERF_CNT_EN.
- Defined: adds outputs o_hit_cnt and o_miss_cnt (32-bit, saturating at 0xFFFFFFFF, reset 0).
  - Hit counts once per LOOKUP cycle with o_stall=0.
  - Miss counts once per LOOKUP→REFILL transition.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package riscv_icache_pkg: icache_state_e enum {LOOKUP, REFILL, FLUSH}; clog2-based width helper functions; way-index type.
- Sub-module riscv_icache_plru (parameter NUM_WAYS):
  - Combinational victim from PLRU bits.
  - Next-PLRU bits from an accessed way.
  - One instance shared across sets; per-set PLRU bits held in the parent.

Test Plan:
- Cold miss, default params, addr 0x1004: o_stall=1; o_mem_req=1 with o_addr_from_control_to_axi=0x1000. Done after 5 cycles with line word1=0xDEADBEEF → next cycle o_stall=0, o_data_to_core=0xDEADBEEF.
- Same-set conflict, NUM_WAYS=2, addrs 0x0000, 0x1000 (both set 0):
  - Both refilled; both then hit with no o_mem_req.
  - Then access 0x2000 → victim is the LRU way (way holding 0x0000 if 0x1000 was accessed last).
  - Re-access 0x1000 hits.
- Flush, NUM_SETS=128: pulse i_flush in LOOKUP → o_stall high exactly 128 cycles. Afterwards a previously resident 0x1000 misses (o_mem_req=1).
- Flush during refill: i_flush while o_mem_req=1 → refill still writes on i_mem_done. Then 128 flush cycles; the refilled line subsequently misses.
- Reset mid-refill: assert i_rst_n=0 one cycle during REFILL → o_mem_req=0 next cycle. A stray i_mem_done is ignored; next fetch misses.
- Perf counters with RISCV_ICACHE_PERF_CNT_EN: 1 miss then 3 hits on 0x1000 → o_miss_cnt=1, o_hit_cnt=3.
